exam_loop_ctrl: RTL and testbench
=================================

EXAM_LOOP_CTRL -- requirements
Module: exam_loop_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width.
REQ-002 Parameter CNT_W, default 8, sets the loop counter width; the loop bounds are a[CNT_W-1:0] and b[CNT_W-1:0].
REQ-003 CLOCK_50  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level request to run one computation.
REQ-006 a, b, c, d  input  WIDTH each  operands; a gives the outer bound N, b gives the inner bound M, c and d are addends.
REQ-007 g  output  WIDTH  accumulator result g.
REQ-008 h  output  WIDTH  accumulator result h.
REQ-009 done  output  1  result valid; registered.
REQ-010 busy  output  1  computation in progress; registered.
REQ-011 err  output  1  parity reject flag (see Configuration); registered.

Function
REQ-012 The FSM states shall be IDLE, INIT_O, COND_O, INIT_I, COND_I, BODY, ITER_I, ITER_O, DONE, with one cycle per state visit.
REQ-013 IDLE shall go to INIT_O when start=1 and shall latch a, b, c, d internally on that edge; operand changes after that edge shall be ignored.
REQ-014 INIT_O shall set i=0, g=0, h=0 and err=0, then go to COND_O.
REQ-015 COND_O shall go to INIT_I if i<N, else to DONE.
REQ-016 INIT_I shall set j=0, then go to COND_I.
REQ-017 COND_I shall go to BODY if j<M, else to ITER_O.
REQ-018 BODY shall do g<=g+c and h<=h+d+i (i zero-extended to WIDTH), then go to ITER_I.
REQ-019 ITER_I shall do j<=j+1, then go to COND_I.
REQ-020 ITER_O shall do i<=i+1, then go to COND_O.
REQ-021 All arithmetic shall be modulo 2^WIDTH with no saturation; i and j shall never overflow, because the compare precedes the increment and the bounds fit in CNT_W bits.
REQ-022 done shall be 1 exactly while the state is DONE.
REQ-023 busy shall be 1 in every state except IDLE and DONE.
REQ-024 done shall go 1 at the rising edge numbered 3+N*(3M+4), counting the start-sampling edge as edge 1.
REQ-025 DONE shall hold while start=1 and shall go to IDLE on the first edge with start=0; done shall clear on that edge.
REQ-026 g and h shall hold their last values in IDLE and DONE until the next INIT_O.
REQ-027 N=0 shall skip to DONE with g=h=0; M=0 shall run the outer loop with g and h unchanged.
REQ-028 Any illegal state encoding shall go to IDLE on the next edge.

Reset
REQ-029 While rst=0, the block shall immediately set state=IDLE, g=0, h=0, done=0, busy=0, err=0, i=0, j=0 and clear the latched operands, including mid-computation.
REQ-030 After rst rises, the block shall start no run until start is sampled 1 in IDLE.

Configuration
REQ-031 With LOOP_CTRL_PARITY_EN defined, INIT_O shall check the latched a for odd parity; on failure (even number of ones) it shall set g=h=all-ones and err=1 and go directly to DONE, with done going 1 at edge 3.
REQ-032 Without LOOP_CTRL_PARITY_EN, no parity check shall be performed and err shall be constant 0.

Verification
REQ-033 Nominal run: a=2, b=3, c=5, d=1, start=1 -> done=1 at edge 29, g=30, h=9, busy=1 on edges 1-28.
REQ-034 Zero outer bound: a=0, start=1 -> done=1 at edge 3, g=0, h=0.
REQ-035 Wrap-around: a=255, b=255, c=16'hFFFF, d=0 -> done at edge 196098, g=511, h=639.
REQ-036 Mid-run reset: rst=0 at edge 10 of the REQ-033 run -> g=h=0, done=0, busy=0 immediately; a new start then produces the REQ-033 results.
REQ-037 Handshake: change a to 9 at edge 2 -> result unchanged at 30/9; hold start=1 after done -> done stays 1; start=0 -> done=0 and busy=0 after the next edge.
REQ-038 Parity reject, with LOOP_CTRL_PARITY_EN defined: a=16'h0003 -> done at edge 3, err=1, g=h=16'hFFFF; a=16'h0001 runs normally with err=0.

Source files
------------

// File: rtl/exam_loop_ctrl.sv
// rtl/exam_loop_ctrl.sv - nested-loop accumulator controller (optional LOOP_CTRL_PARITY_EN)
module exam_loop_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic             done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT_O = 4'd1,
        COND_O = 4'd2,
        INIT_I = 4'd3,
        COND_I = 4'd4,
        BODY   = 4'd5,
        ITER_I = 4'd6,
        ITER_O = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic [CNT_W-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [WIDTH-1:0]   h_q, h_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               reject;

    // Upper operand bits only matter for the optional parity check.
    logic unused_bits;
    assign unused_bits = ^{a, b};

`ifdef LOOP_CTRL_PARITY_EN
    logic a_odd_q, a_odd_d;
    logic err_q, err_d;
    assign reject = err_q;
    assign err    = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    // Next-state and datapath updates; one state visit per clock.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        c_d     = c_q;
        d_d     = d_q;
        i_d     = i_q;
        j_d     = j_q;
        g_d     = g_q;
        h_d     = h_q;
`ifdef LOOP_CTRL_PARITY_EN
        a_odd_d = a_odd_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = a[CNT_W-1:0];
                    m_d     = b[CNT_W-1:0];
                    c_d     = c;
                    d_d     = d;
`ifdef LOOP_CTRL_PARITY_EN
                    a_odd_d = ^a;
`endif
                    state_d = INIT_O;
                end
            end
            INIT_O: begin
                i_d     = '0;
                g_d     = '0;
                h_d     = '0;
`ifdef LOOP_CTRL_PARITY_EN
                err_d   = 1'b0;
                if (!a_odd_q) begin
                    g_d   = '1;
                    h_d   = '1;
                    err_d = 1'b1;
                end
`endif
                state_d = COND_O;
            end
            // A parity reject exits here so its done timing equals the N=0 case.
            COND_O: begin
                if (!reject && (i_q < n_q)) state_d = INIT_I;
                else                        state_d = DONE;
            end
            INIT_I: begin
                j_d     = '0;
                state_d = COND_I;
            end
            COND_I: begin
                if (j_q < m_q) state_d = BODY;
                else           state_d = ITER_O;
            end
            BODY: begin
                g_d     = g_q + c_q;
                h_d     = h_q + d_q + WIDTH'(i_q);
                state_d = ITER_I;
            end
            ITER_I: begin
                j_d     = j_q + CNT_W'(1);
                state_d = COND_I;
            end
            ITER_O: begin
                i_d     = i_q + CNT_W'(1);
                state_d = COND_O;
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            c_q     <= c_d;
            d_q     <= d_d;
            i_q     <= i_d;
            j_q     <= j_d;
            g_q     <= g_d;
            h_q     <= h_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef LOOP_CTRL_PARITY_EN
    // Parity bookkeeping registers, cleared with the rest of the state.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            a_odd_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            a_odd_q <= a_odd_d;
            err_q   <= err_d;
        end
    end
`endif

    assign g    = g_q;
    assign h    = h_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_exam_loop_ctrl.sv
// tb/tb_exam_loop_ctrl.sv - scoreboard bench for exam_loop_ctrl
module tb_exam_loop_ctrl;
    localparam int W  = 16;
    localparam int CW = 8;

    logic          CLOCK_50 = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
    logic [W-1:0]  g, h;
    logic          done, busy, err;

    exam_loop_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .g        (g),
        .h        (h),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] h;
        logic         e;
        int           edge_n;
        int           start_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Closed-form reference: g = N*M*c, h = M*(N*d + N(N-1)/2), done edge 3+N(3M+4).
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic [W-1:0] cc, input logic [W-1:0] dd);
        exp_t r;
        longint n, m, gg, hh;
        n  = longint'(aa[CW-1:0]);
        m  = longint'(bb[CW-1:0]);
        gg = n * m * longint'(cc);
        hh = m * (n * longint'(dd) + (n * (n - 1)) / 2);
        r.g = gg[W-1:0];
        r.h = hh[W-1:0];
        r.e = 1'b0;
        r.edge_n = 3 + int'(n) * (3 * int'(m) + 4);
        r.start_cyc = 0;
`ifdef LOOP_CTRL_PARITY_EN
        if (^aa == 1'b0) begin
            r.g = '1;
            r.h = '1;
            r.e = 1'b1;
            r.edge_n = 3;
        end
`endif
        return r;
    endfunction

    // Monitor: every rising done pops one expectation.
    logic done_prev = 1'b0;
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("g", g, e.g);
                check("h", h, e.h);
                check("err", err, e.e);
                check("done_edge", 64'(cyc - e.start_cyc + 1), 64'(e.edge_n));
            end
        end
        done_prev = done;
    end

    task automatic run(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] cc, input logic [W-1:0] dd,
                       input bit chg, input int hold);
        exp_t e;
        int   n = 0;
        int   busy_bad = 0;
        @(negedge CLOCK_50);
        a = aa; b = bb; c = cc; d = dd;
        start = 1'b1;
        e = model(aa, bb, cc, dd);
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge CLOCK_50);
        if (chg) begin
            a = 16'd9;
            b = W'($urandom);
            c = W'($urandom);
            d = W'($urandom);
        end
        while (!done && n < 2000) begin
            if (!busy) busy_bad++;
            @(negedge CLOCK_50);
            n++;
        end
        check("done_timeout", done, 1);
        check("busy_in_run", 64'(busy_bad), 0);
        check("busy_at_done", busy, 0);
        repeat (hold) @(negedge CLOCK_50);
        check("done_hold", done, 1);
        start = 1'b0;
        @(negedge CLOCK_50);
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("g_hold", g, e.g);
        check("h_hold", h, e.h);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        check("rst_g", g, 0);
        check("rst_h", h, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        run(16'd2, 16'd3, 16'd5, 16'd1, 1'b1, 3);
        run(16'd0, 16'd7, 16'd5, 16'd1, 1'b0, 0);
        run(16'd4, 16'd0, 16'd5, 16'd1, 1'b0, 1);
        run(16'd15, 16'd15, 16'hFFFF, 16'hFFF0, 1'b0, 0);
        run(16'h0103, 16'hFF02, 16'h1234, 16'h0077, 1'b0, 2);

        // Mid-run reset on edge 10 of the nominal run.
        @(negedge CLOCK_50);
        a = 16'd2; b = 16'd3; c = 16'd5; d = 16'd1;
        start = 1'b1;
        repeat (9) @(negedge CLOCK_50);
        start = 1'b0;
        @(posedge CLOCK_50);
        #1 rst = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_g", g, 0);
        check("mid_rst_h", h, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge CLOCK_50);
        rst = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        run(16'd2, 16'd3, 16'd5, 16'd1, 1'b0, 0);

`ifdef LOOP_CTRL_PARITY_EN
        run(16'h0003, 16'd3, 16'd5, 16'd1, 1'b0, 0);
        run(16'h0001, 16'd3, 16'd5, 16'd1, 1'b0, 0);
`endif

        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            ra[CW-1:0] = CW'($urandom_range(0, 12));
            rb[CW-1:0] = CW'($urandom_range(0, 12));
            run(ra, rb, W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(negedge CLOCK_50);
        check("sb_drained", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
